// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial: digit-serial packed-BCD add/subtract, LSD first; define BCD_SIGN_MAG_EN for sign-magnitude subtraction results
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                neg,
  output logic                err
);
  localparam int W = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
`ifdef BCD_SIGN_MAG_EN
  typedef enum logic [1:0] {IDLE, RUN, NEGATE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic [IW-1:0] idx_q, idx_d;
  logic sub_q, sub_d, c_q, c_d, inv_q, inv_d, cout_q, cout_d, err_q, err_d;
  logic bad, op, last, cnext;
  logic [3:0] x, y, dig;
  logic [4:0] sa, sd;
`ifdef BCD_SIGN_MAG_EN
  logic neg_q, neg_d;
  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif
  assign busy   = state_q != IDLE && state_q != DONE;
  assign done   = state_q == DONE;
  assign result = result_q;
  assign cout   = cout_q;
  assign err    = err_q;
  // flag any non-decimal digit on the incoming operands
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | (a[4*i+:4] > 4'd9) | (b[4*i+:4] > 4'd9);
  end
  // one digit step per cycle; NEGATE reuses the subtract path as 0 - result
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    result_d = result_q;
    idx_d    = idx_q;
    sub_d    = sub_q;
    c_d      = c_q;
    inv_d    = inv_q;
    cout_d   = cout_q;
    err_d    = err_q;
`ifdef BCD_SIGN_MAG_EN
    neg_d    = neg_q;
`endif
    last  = idx_q == IW'(DIGITS - 1);
    x     = state_q == RUN ? a_q[3:0] : 4'd0;
    y     = state_q == RUN ? b_q[3:0] : res_q[3:0];
    op    = state_q == RUN ? sub_q : 1'b1;
    sa    = {1'b0, x} + {1'b0, y} + {4'd0, c_q};
    sd    = {1'b0, x} - {1'b0, y} - {4'd0, c_q};
    cnext = op ? sd[4] : sa > 5'd9;
    dig   = op ? (sd[4] ? 4'(sd + 5'd10) : sd[3:0]) : (cnext ? 4'(sa - 5'd10) : sa[3:0]);
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        sub_d   = sub;
        inv_d   = bad;
        idx_d   = '0;
        c_d     = 1'b0;
        state_d = RUN;
      end
      DONE: state_d = IDLE;
      default: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        res_d = W'({dig, res_q} >> 4);
        c_d   = cnext;
        idx_d = idx_q + 1'b1;
        if (last) begin
          state_d = DONE;
          idx_d   = '0;
          c_d     = 1'b0;
`ifdef BCD_SIGN_MAG_EN
          if (state_q == RUN && sub_q && cnext && !inv_q) state_d = NEGATE;
`endif
        end
      end
    endcase
    if (state_d == DONE) begin
      result_d = inv_q ? '0 : res_d;
      cout_d   = !inv_q && (cnext || state_q != RUN);
      err_d    = inv_q;
`ifdef BCD_SIGN_MAG_EN
      neg_d    = state_q == NEGATE;
`endif
    end
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      sub_q    <= 1'b0;
      c_q      <= 1'b0;
      inv_q    <= 1'b0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef BCD_SIGN_MAG_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      sub_q    <= sub_d;
      c_q      <= c_d;
      inv_q    <= inv_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
`ifdef BCD_SIGN_MAG_EN
      neg_q    <= neg_d;
`endif
    end
  end
endmodule
